// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared event type and sizing helpers for key_scan
package key_scan_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int MAX_IW      = 8;

  typedef struct packed {
    logic              press;
    logic [MAX_IW-1:0] idx;
  } evt_t;

  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Bits needed to hold the values 0..max_val.
  function automatic int ctr_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

  // Packs an event as {press, idx} with press sitting just above an iw-bit index.
  function automatic logic [MAX_IW:0] evt_pack(input evt_t e, input int iw);
    return ({{MAX_IW{1'b0}}, e.press} << iw) | {1'b0, e.idx};
  endfunction

endpackage

// File: rtl/key_scan_fifo.sv
// rtl/key_scan_fifo.sv - DEPTH x DW synchronous event FIFO with occupancy count
module key_scan_fifo
  import key_scan_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  DW    = 4,
  localparam int CW    = cnt_width(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop, wr_en;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop      = ~empty & out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en    = push & (~full | pop);
  assign out_data = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/key_scan.sv
// rtl/key_scan.sv - key line synchroniser, debouncer and press/release event source
// Optional auto-repeat press events are built when KEY_SCAN_REPEAT_EN is defined.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int  WIDTH  = 8,
  parameter int  STEP   = 10,
  parameter int  LEN    = 4,
  parameter int  DEPTH  = 4,
  parameter int  REPEAT = 64,
  localparam int IW     = idx_width(WIDTH),
  localparam int CW     = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IW:0]      evt_data,
  output logic [CW-1:0]    fifo_cnt
);

  localparam int PSW = ctr_width(STEP - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [PSW-1:0]   presc_q, presc_d;
  logic [7:0]       stab_q [WIDTH];
  logic [7:0]       stab_d [WIDTH];
  logic [WIDTH-1:0] key_state_q, key_state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] toggle, push_clr, rep_fire;
  logic             tick, sel_found, push, fifo_full, fifo_empty;
  logic [IW-1:0]    sel_idx;
  logic [IW:0]      push_data;
  evt_t             ev;

  assign tick      = (presc_q == PSW'(STEP - 1));
  assign key_state = key_state_q;
  assign evt_valid = ~fifo_empty;

  always_comb begin
    sync_d[0] = key_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    presc_d = tick ? '0 : presc_q + PSW'(1);

    toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      stab_d[i] = stab_q[i];
      if (tick) begin
        if (sync_q[SYNC_STAGES-1][i] == key_state_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == 8'(LEN - 1)) begin
          stab_d[i] = '0;
          toggle[i] = 1'b1;
        end else begin
          stab_d[i] = stab_q[i] + 8'd1;
        end
      end
    end
    key_state_d = key_state_q ^ toggle;

    // Lowest-index pending key wins; scanning downward leaves it in sel_idx.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    push      = sel_found & ~fifo_full;
    push_clr  = push ? (WIDTH'(1) << sel_idx) : '0;
    ev.press  = key_state_q[sel_idx];
    ev.idx    = MAX_IW'(sel_idx);
    push_data = (IW + 1)'(evt_pack(ev, IW));
  end

`ifdef KEY_SCAN_REPEAT_EN
  localparam int RW = ctr_width(REPEAT - 1);

  logic [RW-1:0] rep_q [WIDTH];
  logic [RW-1:0] rep_d [WIDTH];

  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rep_d[i] = rep_q[i];
      if (toggle[i] || !key_state_q[i]) begin
        rep_d[i] = '0;
      end else if (tick) begin
        if (rep_q[i] == RW'(REPEAT - 1)) begin
          rep_d[i]    = '0;
          rep_fire[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        rep_q[i] <= '0;
      end
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  // REPEAT is legal only from 1 upward, so this never fires.
  assign rep_fire = {WIDTH{REPEAT < 1}};
`endif

  // A second toggle before the push cancels the first: net level unchanged.
  assign pend_d = ((pend_q & ~push_clr) ^ toggle) | rep_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        stab_q[i] <= '0;
      end
      presc_q     <= '0;
      key_state_q <= '0;
      pend_q      <= '0;
    end else begin
      sync_q      <= sync_d;
      stab_q      <= stab_d;
      presc_q     <= presc_d;
      key_state_q <= key_state_d;
      pend_q      <= pend_d;
    end
  end

  key_scan_fifo #(
    .DEPTH (DEPTH),
    .DW    (IW + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .out_ready (evt_ready),
    .out_data  (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .cnt       (fifo_cnt)
  );

endmodule
